// File: rtl/pc_redirect_unit.sv
// Fetch PC register with branch/jr redirect and a fixed-length front-end flush.
// Optional PC_ALIGN_CHECK_EN: word-align jr targets and flag misaligned ones.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic        bne_i,
    input  logic        zero_i,
    input  logic [31:0] br_pc4_i,
    input  logic [31:0] br_offset_i,
    input  logic        jr_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic        misalign_o
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        redirect_q, redirect_d;
    logic        misalign_q, misalign_d;

    logic        taken;
    logic        req;
    logic        jr_mis;
    logic [31:0] br_tgt;
    logic [31:0] jr_tgt;
    logic [31:0] tgt;

    assign taken  = branch_i & (zero_i ^ bne_i);
    assign br_tgt = br_pc4_i + br_offset_i;

`ifdef PC_ALIGN_CHECK_EN
    assign jr_tgt = {jr_addr_i[31:2], 2'b00};
    assign jr_mis = jr_i & (|jr_addr_i[1:0]);
`else
    assign jr_tgt = jr_addr_i;
    assign jr_mis = 1'b0;
`endif

    // Wrong-path control flow is ignored while flushing.
    assign req = (state_q == RUN) & (jr_i | taken);
    assign tgt = jr_i ? jr_tgt : br_tgt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= RUN;
            cnt_q      <= 3'd0;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (req) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_INIT;
                end
            end
            FLUSH: begin
                // Stall does not freeze the count.
                if (cnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
        endcase
    end

    always_comb begin
        flush_d    = (state_d == FLUSH);
        redirect_d = req;
        misalign_d = req & jr_mis;
        pc_d       = pc_q;
        priority case (1'b1)
            req:     pc_d = tgt;
            stall_i: pc_d = pc_q;
            default: pc_d = pc_q + 32'd4;
        endcase
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + 32'd4;
    assign flush_o    = flush_q;
    assign redirect_o = redirect_q;
    assign misalign_o = misalign_q;

endmodule
